// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if
// Bundles the operation handshake, decoder link and result handshake of the
// ALU sequencer.
//   in_valid/in_ready        operation offer / accept
//   in_opcode, in_a, in_b    operation code and operands
//   dec_opcode, dec_enable   registered opcode out, one-hot unit enable back
//   out_valid/out_ready      result offer / accept
//   out_result, out_err      result and illegal-operation flag
//   busy                     sequencer not idle
// slave is the sequencer side; master is the producer/consumer/decoder side.
interface alu_exec_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_opcode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [3:0]       dec_opcode;
   logic [6:0]       dec_enable;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_err;
   logic             busy;

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, dec_enable, out_ready,
      output in_ready, dec_opcode, out_valid, out_result, out_err, busy
   );

   modport master (
      output in_valid, in_opcode, in_a, in_b, dec_enable, out_ready,
      input  in_ready, dec_opcode, out_valid, out_result, out_err, busy
   );
endinterface

// File: rtl/alu_exec_seq.sv
// alu_exec_seq
// Sequencing front end for the ALU datapath. Takes one operation at a time,
// registers it, lets the external decoder pick the unit, executes logic and
// add/sub/compare in one cycle and shifts one bit per cycle, then holds the
// result until the consumer accepts it.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    alu_exec_seq_if.slave (see interface file for signal list)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for an operation, in_ready high
// S_EXEC  | decoder enable sampled, single-cycle ops resolved, shift set up
// S_SHIFT | one shift step per cycle until the count runs out
// S_DONE  | result offered on out_valid until out_ready
module alu_exec_seq #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   alu_exec_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_e;
   typedef enum logic [1:0] {K_SLL, K_SRL, K_SRA} kind_e;

   state_e           state_q, state_d;
   logic [3:0]       opc_q, opc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   kind_e            kind_q, kind_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] sh_next;

   // Arithmetic right shift keeps the MSB in place, so replicating the
   // current MSB is the same as filling with the original a[WIDTH-1].
   always_comb begin
      sh_next = sh_q;
      case (kind_q)
         K_SLL:   sh_next = {sh_q[WIDTH-2:0], 1'b0};
         K_SRL:   sh_next = {1'b0, sh_q[WIDTH-1:1]};
         default: sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      res_d   = res_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               opc_d   = bus.in_opcode;
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_DONE;
            if (!$onehot(bus.dec_enable)) begin
               res_d = '0;
               err_d = 1'b1;
            end else if (bus.dec_enable[0]) begin
               res_d = a_q & b_q;
               err_d = 1'b0;
            end else if (bus.dec_enable[1]) begin
               res_d = a_q | b_q;
               err_d = 1'b0;
            end else if (bus.dec_enable[2]) begin
               res_d = a_q ^ b_q;
               err_d = 1'b0;
            end else if (bus.dec_enable[3]) begin
               err_d = 1'b0;
               case (opc_q)
                  4'b0011: res_d = a_q + b_q;
                  4'b0100: res_d = a_q - b_q;
                  4'b0101: res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                  4'b0110: res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
                  default: begin
                     // addsub unit enabled for an opcode it cannot execute
                     res_d = '0;
                     err_d = 1'b1;
                  end
               endcase
            end else begin
               sh_d  = a_q;
               cnt_d = b_q[SHW-1:0];
               if (bus.dec_enable[4])      kind_d = K_SLL;
               else if (bus.dec_enable[5]) kind_d = K_SRL;
               else                        kind_d = K_SRA;
               if (b_q[SHW-1:0] == '0) begin
                  res_d = a_q;
                  err_d = 1'b0;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
               res_d   = sh_next;
               err_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         opc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         kind_q  <= K_SLL;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE) && rst_n;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.dec_opcode = opc_q;
   assign bus.out_result = res_q;
   assign bus.out_err    = err_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   logic       dec_force = 1'b0;
   logic [6:0] dec_force_val = '0;

   alu_exec_seq_if #(.WIDTH(W)) bus ();

   alu_exec_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec_model(input logic [3:0] op);
      case (op)
         4'd0:                     return 7'b0000001;
         4'd1:                     return 7'b0000010;
         4'd2:                     return 7'b0000100;
         4'd3, 4'd4, 4'd5, 4'd6:   return 7'b0001000;
         4'd7:                     return 7'b0010000;
         4'd8:                     return 7'b0100000;
         4'd9:                     return 7'b1000000;
         default:                  return 7'b0000000;
      endcase
   endfunction

   assign bus.dec_enable = dec_force ? dec_force_val : dec_model(bus.dec_opcode);

   // Reference: result, error flag and number of edges after the accept edge
   // until out_valid is seen.
   task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic err, output int lat);
      int sh;
      sh  = int'(b % W);
      res = '0;
      err = 1'b0;
      lat = 1;
      case (op)
         4'd0: res = a & b;
         4'd1: res = a | b;
         4'd2: res = a ^ b;
         4'd3: res = a + b;
         4'd4: res = a - b;
         4'd5: res = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd6: res = (a < b) ? 1 : 0;
         4'd7: begin res = a << sh; lat = (sh == 0) ? 1 : sh + 1; end
         4'd8: begin res = a >> sh; lat = (sh == 0) ? 1 : sh + 1; end
         4'd9: begin res = $unsigned($signed(a) >>> sh); lat = (sh == 0) ? 1 : sh + 1; end
         default: err = 1'b1;
      endcase
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Offer an op, let it be accepted, wait for out_valid and check latency.
   task automatic start_wait(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_res, input logic exp_err, input int exp_lat);
      int cyc;
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_a      = a;
      bus.in_b      = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("dec_opcode", bus.dec_opcode, op);
      cyc = 0;
      while (!bus.out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("latency", cyc, exp_lat);
      chk("result", bus.out_result, exp_res);
      chk("err", bus.out_err, exp_err);
   endtask

   task automatic finish_op(input int hold);
      logic [W-1:0] r;
      logic         e;
      r = bus.out_result;
      e = bus.out_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_result", {bus.out_err, bus.out_result}, {e, r});
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("valid_clr", bus.out_valid, 0);
      chk("ready_back", bus.in_ready, 1);
      chk("result_keep", bus.out_result, r);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [W-1:0] r;
      logic         e;
      int           l;
      ref_op(op, a, b, r, e, l);
      start_wait(op, a, b, r, e, l);
      finish_op(hold);
   endtask

   initial begin
      int vcount;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready_low", bus.in_ready, 0);
      chk("rst_result", bus.out_result, 0);
      chk("rst_dec_opcode", bus.dec_opcode, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready_high", bus.in_ready, 1);

      // Directed vectors with literal expectations
      start_wait(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0100, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0011, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
      finish_op(0);
      start_wait(4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
      finish_op(0);
      start_wait(4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5);
      finish_op(0);
      start_wait(4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 5);
      finish_op(0);
      start_wait(4'b0111, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32);
      finish_op(0);
      start_wait(4'b1001, 32'hA5A5_0001, 32'h0000_0040, 32'hA5A5_0001, 1'b0, 1);
      finish_op(0);
      start_wait(4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);
      finish_op(0);
      start_wait(4'b1010, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);
      finish_op(0);
      start_wait(4'b0011, 32'h7, 32'h8, 32'hF, 1'b0, 1);
      finish_op(0);
      dec_force     = 1'b1;
      dec_force_val = 7'b0000011;
      start_wait(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
      finish_op(0);
      dec_force = 1'b0;

      // Backpressure with a second op offered while DONE
      start_wait(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_opcode = 4'b0001;
      bus.in_a      = 32'h1000_0000;
      bus.in_b      = 32'h0000_0003;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", bus.out_valid, 1);
         chk("bp_result", {bus.out_err, bus.out_result}, {1'b0, 32'h0F00_0F00});
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_dec_opcode", bus.dec_opcode, 4'b0000);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("bp_release_valid", bus.out_valid, 0);
      chk("bp_release_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp_accept_opcode", bus.dec_opcode, 4'b0001);
      chk("bp_accept_busy", bus.in_ready, 0);
      @(posedge clk);
      #1;
      chk("bp_second_valid", bus.out_valid, 1);
      chk("bp_second_result", bus.out_result, 32'h1000_0003);
      finish_op(0);

      // Randomized ops against the reference model
      for (int n = 0; n < 150; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'hFFFF_FFE0;
         run_op(op, a, b, $urandom_range(0, 2));
      end

      // Reset in the middle of a shift
      run_op(4'b0001, 32'h5555_0000, 32'h0000_AAAA, 0);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_opcode = 4'b1001;
      bus.in_a      = 32'h8000_0000;
      bus.in_b      = 32'd20;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mid_shift_busy", bus.busy, 1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mr_valid", bus.out_valid, 0);
      chk("mr_result", bus.out_result, 0);
      chk("mr_err", bus.out_err, 0);
      chk("mr_dec_opcode", bus.dec_opcode, 0);
      chk("mr_busy", bus.busy, 0);
      chk("mr_ready_low", bus.in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("mr_ready_high", bus.in_ready, 1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) vcount++;
      end
      chk("mr_no_valid", vcount, 0);
      run_op(4'b0100, 32'd10, 32'd3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Sequencing front end for the ALU datapath. Accepts one operation at a time over a valid/ready handshake and registers it. It drives the registered opcode to the ALU opcode decoder and consumes the decoder's one-hot unit enable. It executes logic/add-sub ops in one cycle and shifts iteratively (one bit per cycle), then holds the result on a valid/ready output until the consumer takes it.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 8; SHW = log2(WIDTH)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept; = (state==IDLE) && rst_n
- in_opcode  in  4  operation code
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B; shift amount is in_b[SHW-1:0], upper bits ignored
- dec_opcode  out  4  registered opcode to decoder
- dec_enable  in  7  one-hot from decoder: bit0 and, 1 or, 2 xor, 3 addsub, 4 sll, 5 srl, 6 sra
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_err  out  1  operation was illegal; qualifies out_result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register opcode→dec_opcode and a/b→op_a/op_b. Go to EXEC.
- EXEC (one cycle): sample dec_enable.
  - bit0/1/2: result = a&b / a|b / a^b. Go to DONE.
  - bit3: opcode 0011 → a+b; 0100 → a−b, both mod 2^WIDTH. 0101 → slt: 1 if signed a<b else 0. 0110 → sltu: unsigned compare. Go to DONE.
  - bit4/5/6: load shift reg = a, cnt = shamt. If cnt==0, result = a, go to DONE. Otherwise go to SHIFT.
  - dec_enable all-zero, or more than one bit set: result = 0, out_err = 1, go to DONE.
- SHIFT: each cycle, shift one bit and cnt--.
  - sll fills 0; srl fills 0; sra fills the bit that was a[WIDTH-1].
  - After the shift with cnt==1, go to DONE; result = shift reg.
- DONE: out_valid=1. out_result and out_err are stable until accepted. On out_ready, go to IDLE and clear out_valid. out_result and out_err keep their last value.
- in_valid is ignored outside IDLE. There is no overlap between operations.
- Reset (rst_n low at an edge), from any state including mid-SHIFT or DONE:
  - state=IDLE, out_valid=0, out_result=0, out_err=0, dec_opcode=0, busy=0.
  - The operation in flight is discarded and never produces out_valid.

## Timing
- Input handshake at edge k → EXEC during cycle k..k+1. dec_opcode is valid from edge k; the decoder is combinational.
- Non-shift or shamt==0: DONE at edge k+1. out_valid is high after edge k+1, a latency of 2 edges.
- Shift by n>0: SHIFT occupies edges k+2..k+n+1. out_valid rises after edge k+n+1.
- The output handshake at edge m returns to IDLE. in_ready=1 after edge m, so the next accept is at m+1 at the earliest.
- Peak throughput: one non-shift op per 3 cycles.
- in_ready is combinational from state only. No combinational path from in_valid or out_ready to any output.
- Max shift 31 (WIDTH=32) → worst-case latency 33 edges.

## Test plan
- Reset mid-op: start sra, shamt 20. Hold rst_n low 2 cycles at the 5th SHIFT cycle → out_valid never rises; out_result=0, dec_opcode=0. in_ready=1 the first cycle after rst_n goes high.
- Logic/latency: opcode 0000, a=0xF0F0_1234, b=0x0FF0_FFFF, accepted at edge k → out_result=0x00F0_1234, out_err=0, out_valid high after edge k+1. Back-to-back or (0001) and xor (0010) yield a|b and a^b.
- Add/sub/compare:
  - 0100, a=0, b=1 → 0xFFFF_FFFF.
  - 0011, a=0xFFFF_FFFF, b=2 → 0x0000_0001.
  - 0101, a=0xFFFF_FFFF, b=1 → 1.
  - 0110, same operands → 0.
- Shifts:
  - 1001, a=0x8000_0000, b=0x0000_0024 (shamt 4) → 0xF800_0000, out_valid after edge k+5.
  - 1000, same operands → 0x0800_0000.
  - 0111, a=1, b=31 → 0x8000_0000 after edge k+32.
  - shamt 0 → a after edge k+1.
- Illegal: opcode 1111, and also 1010 → out_err=1, out_result=0, out_valid after edge k+1.
- Backpressure: hold out_ready low 5 cycles in DONE with in_valid high → out_valid, out_result and out_err unchanged. in_ready=0, no new capture. The op offered while busy is accepted only after the output handshake.
